// File: rtl/multi_zone_display_controller.sv
// multi_zone_display_controller: 640x480 VGA renderer for a multi-zone
// temperature panel (status block + temperature bar per zone, dividers).
//
// Ports:
//   CLOCK_50     system clock, all logic on its rising edge
//   RESET        synchronous, active-high reset
//   ZONE_TEMP    per-zone temperature, zone k at [k*TEMP_W +: TEMP_W]
//   ZONE_STATUS  per-zone status (00 off, 01 ok, 10 alarm, 11 warn)
//   VGA_CLK      25 MHz pixel clock (CLOCK_50 / 2)
//   VGA_HS/VS    active-low syncs
//   VGA_BLANK_N  high inside the 640x480 active area
//   VGA_R/G/B    pixel colour, each channel 8'h00 or 8'hFF
//   FRAME_START  one-cycle pulse when the inputs are snapshotted
module multi_zone_display_controller #(
    parameter int NUM_ZONES    = 4,
    parameter int TEMP_W       = 10,
    parameter int DIV_HALF     = 5,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                        CLOCK_50,
    input  logic                        RESET,
    input  logic [NUM_ZONES*TEMP_W-1:0] ZONE_TEMP,
    input  logic [2*NUM_ZONES-1:0]      ZONE_STATUS,
    output logic                        VGA_CLK,
    output logic                        VGA_HS,
    output logic                        VGA_VS,
    output logic                        VGA_BLANK_N,
    output logic [7:0]                  VGA_R,
    output logic [7:0]                  VGA_G,
    output logic [7:0]                  VGA_B,
    output logic                        FRAME_START
);

    localparam int ZH = 480 / NUM_ZONES;
    localparam int ZW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
    localparam logic [ZW-1:0] Z_LAST   = ZW'(NUM_ZONES - 1);
    localparam logic [9:0]    ROW_LAST = 10'(ZH - 1);
    localparam logic [9:0]    DIV_LO   = 10'(DIV_HALF);
    localparam logic [9:0]    DIV_HI   = 10'(ZH - DIV_HALF);
    localparam logic [7:0]    FC_LAST  = 8'(BLINK_FRAMES - 1);

    logic                        clk25;
    logic [9:0]                  h;
    logic [9:0]                  v;
    logic [9:0]                  row;
    logic [ZW-1:0]               z;
    logic [7:0]                  fcnt;
    logic                        blink;
    logic [NUM_ZONES*TEMP_W-1:0] sh_temp;
    logic [2*NUM_ZONES-1:0]      sh_stat;

    logic [TEMP_W-1:0] cur_temp;
    logic [1:0]        cur_stat;
    logic [31:0]       temp32;
    logic [9:0]        bar_len;
    logic              active;
    logic              divider;
    logic              in_bar;
    logic [2:0]        rgb;

    assign VGA_CLK = clk25;

    always_comb begin
        cur_temp = sh_temp[int'(z)*TEMP_W +: TEMP_W];
        cur_stat = sh_stat[int'(z)*2 +: 2];
        temp32   = 32'(cur_temp);
        bar_len  = (temp32 > 32'd559) ? 10'd559 : temp32[9:0];
        active   = (h < 10'd640) && (v < 10'd480);
        // Divider band spans DIV_HALF rows on each side of a zone boundary:
        // the top rows of every zone but the first, the bottom rows of every
        // zone but the last. The last zone's row count never wraps, so rows
        // past NUM_ZONES*ZH cannot re-trigger the top band.
        divider  = ((z != '0) && (row < DIV_LO)) ||
                   ((z != Z_LAST) && (row >= DIV_HI));
        in_bar   = (h >= 10'd80) && ((h - 10'd80) < bar_len);
        rgb      = 3'b000;
        if (!active || divider) begin
            rgb = 3'b000;
        end else if (h < 10'd64) begin
            case (cur_stat)
                2'b01:   rgb = 3'b010;
                2'b11:   rgb = 3'b110;
                2'b10:   rgb = blink ? 3'b111 : 3'b100;
                default: rgb = 3'b000;
            endcase
        end else if (in_bar) begin
            rgb = 3'b001;
        end else begin
            rgb = 3'b111;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            clk25       <= 1'b0;
            h           <= '0;
            v           <= '0;
            row         <= '0;
            z           <= '0;
            fcnt        <= '0;
            blink       <= 1'b0;
            sh_temp     <= '0;
            sh_stat     <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            FRAME_START <= 1'b0;
        end else begin
            clk25       <= ~clk25;
            FRAME_START <= 1'b0;
            if (clk25) begin
                VGA_HS      <= !((h >= 10'd656) && (h <= 10'd751));
                VGA_VS      <= !((v >= 10'd490) && (v <= 10'd491));
                VGA_BLANK_N <= active;
                VGA_R       <= {8{rgb[2]}};
                VGA_G       <= {8{rgb[1]}};
                VGA_B       <= {8{rgb[0]}};
                if (h == 10'd799) begin
                    h <= '0;
                    if (v == 10'd524) begin
                        v   <= '0;
                        row <= '0;
                        z   <= '0;
                    end else begin
                        v <= v + 10'd1;
                        if ((z != Z_LAST) && (row == ROW_LAST)) begin
                            row <= '0;
                            z   <= z + 1'b1;
                        end else begin
                            row <= row + 10'd1;
                        end
                    end
                end else begin
                    h <= h + 10'd1;
                end
                if ((h == 10'd0) && (v == 10'd480)) begin
                    sh_temp     <= ZONE_TEMP;
                    sh_stat     <= ZONE_STATUS;
                    FRAME_START <= 1'b1;
                    if (fcnt == FC_LAST) begin
                        fcnt  <= '0;
                        blink <= ~blink;
                    end else begin
                        fcnt <= fcnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_zone_display_controller.sv
// tb_multi_zone_display_controller: scoreboard bench, two instances
// (4 zones / blink 2 frames, and 3 zones / default blink).
module tb_multi_zone_display_controller;

    typedef struct {
        int         k;
        logic       hs;
        logic       vs;
        logic       bl;
        logic [2:0] rgb;
        string      nm;
    } exp_t;

    localparam int FRAME = 420000;

    logic        CLOCK_50 = 1'b0;
    logic        rst [2];
    logic [39:0] temp_a;
    logic [7:0]  stat_a;
    logic [29:0] temp_b;
    logic [5:0]  stat_b;
    logic        vclk [2];
    logic        hs [2];
    logic        vs [2];
    logic        bl [2];
    logic        fs [2];
    logic [7:0]  r [2];
    logic [7:0]  g [2];
    logic [7:0]  b [2];

    int   cyc [2];
    bit   in_rst [2];
    bit   p_hs [2];
    bit   p_vs [2];
    bit   p_fs [2];
    int   h_fall [2];
    int   v_fall [2];
    int   fs_cnt [2];
    int   bl_cnt [2];
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #10 CLOCK_50 = ~CLOCK_50;

    multi_zone_display_controller #(
        .NUM_ZONES(4), .TEMP_W(10), .DIV_HALF(5), .BLINK_FRAMES(2)
    ) u_a (
        .CLOCK_50(CLOCK_50), .RESET(rst[0]),
        .ZONE_TEMP(temp_a), .ZONE_STATUS(stat_a),
        .VGA_CLK(vclk[0]), .VGA_HS(hs[0]), .VGA_VS(vs[0]),
        .VGA_BLANK_N(bl[0]), .VGA_R(r[0]), .VGA_G(g[0]), .VGA_B(b[0]),
        .FRAME_START(fs[0])
    );

    multi_zone_display_controller #(
        .NUM_ZONES(3), .TEMP_W(10), .DIV_HALF(5), .BLINK_FRAMES(30)
    ) u_b (
        .CLOCK_50(CLOCK_50), .RESET(rst[1]),
        .ZONE_TEMP(temp_b), .ZONE_STATUS(stat_b),
        .VGA_CLK(vclk[1]), .VGA_HS(hs[1]), .VGA_VS(vs[1]),
        .VGA_BLANK_N(bl[1]), .VGA_R(r[1]), .VGA_G(g[1]), .VGA_B(b[1]),
        .FRAME_START(fs[1])
    );

    // Bench-side cycle count since reset release, per instance.
    always @(posedge CLOCK_50) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                cyc[i]    <= 0;
                in_rst[i] <= 1'b1;
            end else begin
                cyc[i]    <= cyc[i] + 1;
                in_rst[i] <= 1'b0;
            end
        end
    end

    task automatic check(string nm, int i, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d): got %0h, want %0h", nm, i, act, exp);
        end
    endtask

    task automatic push(int i, int f, int v, int h, logic [2:0] rgb, string nm);
        exp_t e;
        int   p;
        e.k   = f*FRAME + v*800 + h;
        e.hs  = !(h >= 656 && h <= 751);
        e.vs  = !(v >= 490 && v <= 491);
        e.bl  = (h < 640) && (v < 480);
        e.rgb = rgb;
        e.nm  = nm;
        p = 0;
        if (i == 0) begin
            while (p < qa.size() && qa[p].k <= e.k) p++;
            qa.insert(p, e);
        end else begin
            while (p < qb.size() && qb[p].k <= e.k) p++;
            qb.insert(p, e);
        end
    endtask

    task automatic cmp_px(int i, int k, exp_t e);
        logic [26:0] act;
        logic [26:0] exp;
        act = {hs[i], vs[i], bl[i], r[i], g[i], b[i]};
        exp = {e.hs, e.vs, e.bl, {8{e.rgb[2]}}, {8{e.rgb[1]}}, {8{e.rgb[0]}}};
        if (e.k != k) check({e.nm, "_missed"}, i, k, e.k);
        else          check(e.nm, i, act, exp);
    endtask

    task automatic mon(int i);
        int   k;
        int   h;
        int   v;
        exp_t e;
        if (in_rst[i]) begin
            check("reset_out", i,
                  {hs[i], vs[i], bl[i], r[i], g[i], b[i], fs[i], vclk[i]},
                  {1'b1, 1'b1, 27'd0});
            p_hs[i] = 1'b1; p_vs[i] = 1'b1; p_fs[i] = 1'b0;
            h_fall[i] = 0; v_fall[i] = 0; fs_cnt[i] = 0; bl_cnt[i] = 0;
        end else begin
            if (cyc[i] < 40) check("vga_clk", i, vclk[i], cyc[i] % 2);
            k = cyc[i] / 2 - 1;
            h = k % 800;
            v = (k / 800) % 525;
            if (fs[i] && !p_fs[i]) begin
                fs_cnt[i]++;
                check("fs_pos", i, ((cyc[i] % 2) << 20) | (v << 10) | h, 480 << 10);
            end
            p_fs[i] = fs[i];
            if (cyc[i] >= 2 && cyc[i] % 2 == 0) begin
                if (h == 0 && v == 0 && k > 0) begin
                    check("fs_once", i, fs_cnt[i], 1);
                    fs_cnt[i] = 0;
                end
                if (k == 800)   check("blank_line0", i, bl_cnt[i], 640);
                if (k == FRAME) check("blank_frame0", i, bl_cnt[i], 307200);
                if (k < FRAME && bl[i]) bl_cnt[i]++;
                if (k < 3200) begin
                    if (!hs[i] && p_hs[i]) begin
                        if (h_fall[i] > 0) check("hs_period", i, cyc[i] - h_fall[i], 1600);
                        h_fall[i] = cyc[i];
                    end
                    if (hs[i] && !p_hs[i]) check("hs_low", i, cyc[i] - h_fall[i], 192);
                end
                p_hs[i] = hs[i];
                if (!vs[i] && p_vs[i]) begin
                    if (v_fall[i] > 0) check("vs_period", i, cyc[i] - v_fall[i], 840000);
                    v_fall[i] = cyc[i];
                end
                if (vs[i] && !p_vs[i]) check("vs_low", i, cyc[i] - v_fall[i], 3200);
                p_vs[i] = vs[i];
                if (i == 0) begin
                    while (qa.size() > 0 && qa[0].k <= k) begin
                        e = qa.pop_front();
                        cmp_px(i, k, e);
                    end
                end else begin
                    while (qb.size() > 0 && qb[0].k <= k) begin
                        e = qb.pop_front();
                        cmp_px(i, k, e);
                    end
                end
            end
        end
    endtask

    always @(negedge CLOCK_50) begin
        mon(0);
        mon(1);
    end

    task automatic wait_px(int i, int f, int v, int h);
        int t;
        t = 2 * (f*FRAME + v*800 + h + 1);
        while (cyc[i] < t) @(negedge CLOCK_50);
    endtask

    initial begin
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        temp_a = {10'd560, 10'd0, 10'd1023, 10'd100};
        stat_a = {2'b00, 2'b11, 2'b10, 2'b01};
        temp_b = {10'd0, 10'd0, 10'd20};
        stat_b = {2'b00, 2'b00, 2'b01};
        repeat (4) @(negedge CLOCK_50);

        // dut0, frame 0 renders from cleared shadows: all zones off, no bars
        push(0, 0, 0, 0, 3'b000, "a_px00");
        push(0, 0, 0, 639, 3'b111, "a_h639");
        push(0, 0, 0, 640, 3'b000, "a_h640");
        push(0, 0, 0, 655, 3'b000, "a_hs655");
        push(0, 0, 0, 656, 3'b000, "a_hs656");
        push(0, 0, 0, 751, 3'b000, "a_hs751");
        push(0, 0, 0, 752, 3'b000, "a_hs752");
        push(0, 0, 20, 100, 3'b111, "a_f0_nobar");
        push(0, 0, 116, 100, 3'b000, "a_f0_div");
        push(0, 0, 479, 639, 3'b111, "a_v479");
        push(0, 0, 480, 0, 3'b000, "a_v480");
        push(0, 0, 489, 799, 3'b000, "a_vs489");
        push(0, 0, 490, 0, 3'b000, "a_vs490");
        push(0, 0, 491, 799, 3'b000, "a_vs491");
        push(0, 0, 492, 0, 3'b000, "a_vs492");
        // dut0, frame 1: z0 ok/100, z1 alarm/1023, z2 warn/0, z3 off/560
        push(0, 1, 20, 0, 3'b010, "a_z0_blk0");
        push(0, 1, 20, 63, 3'b010, "a_z0_blk63");
        push(0, 1, 20, 64, 3'b111, "a_gap64");
        push(0, 1, 20, 79, 3'b111, "a_gap79");
        push(0, 1, 20, 80, 3'b001, "a_bar80");
        push(0, 1, 20, 179, 3'b001, "a_bar179");
        push(0, 1, 20, 180, 3'b111, "a_bar180");
        push(0, 1, 114, 70, 3'b111, "a_div114");
        push(0, 1, 115, 70, 3'b000, "a_div115");
        push(0, 1, 124, 70, 3'b000, "a_div124");
        push(0, 1, 125, 70, 3'b111, "a_div125");
        push(0, 1, 125, 0, 3'b100, "a_blink_f1");
        push(0, 1, 130, 638, 3'b001, "a_sat638");
        push(0, 1, 130, 639, 3'b111, "a_sat639");
        push(0, 1, 234, 100, 3'b001, "a_div234");
        push(0, 1, 235, 100, 3'b000, "a_div235");
        push(0, 1, 244, 100, 3'b000, "a_div244");
        push(0, 1, 245, 100, 3'b111, "a_div245");
        push(0, 1, 245, 80, 3'b111, "a_temp0_h80");
        push(0, 1, 250, 0, 3'b110, "a_warn");
        push(0, 1, 400, 0, 3'b000, "a_off");
        push(0, 1, 400, 638, 3'b001, "a_z3_638");
        push(0, 1, 400, 639, 3'b111, "a_z3_639");

        // dut1, frame 0 dividers (ZH=160), then frame 1 from snapshot
        push(1, 0, 0, 0, 3'b000, "b_px00");
        push(1, 0, 20, 0, 3'b000, "b_f0_off");
        push(1, 0, 154, 100, 3'b111, "b_div154");
        push(1, 0, 155, 100, 3'b000, "b_div155");
        push(1, 0, 164, 100, 3'b000, "b_div164");
        push(1, 0, 165, 100, 3'b111, "b_div165");
        push(1, 0, 314, 100, 3'b111, "b_div314");
        push(1, 0, 315, 100, 3'b000, "b_div315");
        push(1, 0, 324, 100, 3'b000, "b_div324");
        push(1, 0, 325, 100, 3'b111, "b_div325");
        push(1, 1, 20, 0, 3'b010, "b_f1_ok");
        push(1, 1, 20, 99, 3'b001, "b_bar99");
        push(1, 1, 20, 100, 3'b111, "b_bar100");

        rst[0] = 1'b0;
        rst[1] = 1'b0;

        fork
            begin
                wait_px(0, 1, 200, 0);
                temp_a[9:0] = 10'd50;
                push(0, 2, 20, 129, 3'b001, "a_f2_bar129");
                push(0, 2, 20, 130, 3'b111, "a_f2_bar130");
                push(0, 2, 125, 0, 3'b111, "a_blink_f2");
                wait_px(0, 2, 100, 0);
                temp_a[9:0] = 10'd200;
                push(0, 2, 110, 129, 3'b001, "a_hold129");
                push(0, 2, 110, 130, 3'b111, "a_hold130");
                push(0, 3, 20, 279, 3'b001, "a_f3_bar279");
                push(0, 3, 20, 280, 3'b111, "a_f3_bar280");
                push(0, 3, 125, 0, 3'b111, "a_blink_f3");
                push(0, 4, 125, 0, 3'b100, "a_blink_f4");
                wait_px(0, 4, 126, 0);
            end
            begin
                wait_px(1, 1, 300, 0);
                rst[1] = 1'b1;
                @(negedge CLOCK_50);
                push(1, 0, 0, 0, 3'b000, "b_rst_px00");
                push(1, 0, 0, 1, 3'b000, "b_rst_px01");
                push(1, 0, 2, 0, 3'b000, "b_rst_shadow");
                push(1, 0, 2, 100, 3'b111, "b_rst_h100");
                push(1, 0, 155, 100, 3'b000, "b_rst_div155");
                push(1, 1, 20, 0, 3'b010, "b_rst_f1_ok");
                repeat (2) @(negedge CLOCK_50);
                rst[1] = 1'b0;
                wait_px(1, 1, 21, 0);
            end
        join

        repeat (4) @(negedge CLOCK_50);
        check("qa_drained", 0, qa.size(), 0);
        check("qb_drained", 1, qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
